vga_write_arbiter: RTL and testbench
====================================

Name: vga_write_arbiter

Overview:
- Sole owner of the VGA adapter write port (plot_x/plot_y/plot_colour/plot_en).
- Contains an internal screen-clear sweep engine.
- Shares the write port between two pixel requesters: A = food/dot plotter, B = snake renderer.
- Arbitration is round-robin with a per-pixel req/ack handshake.
- All VGA-side outputs are registered.

Parameters:
- X_MAX, 159: last valid x column; coordinates above this are out of range.
- Y_MAX, 119: last valid y row.
- CLEAR_ON_RESET, 1: 1 = enter CLEAR on reset release; 0 = enter ARB.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- clear_req  in  1  single-cycle pulse; start a full-screen clear
- clear_colour  in  3  fill colour; sampled on clear start
- req_a  in  1  requester A has a pixel pending
- x_a  in  8  requester A pixel x
- y_a  in  7  requester A pixel y
- colour_a  in  3  requester A pixel colour
- ack_a  out  1  one-cycle pulse; A's pixel consumed
- req_b, x_b, y_b, colour_b  in  1/8/7/3  same fields for requester B
- ack_b  out  1  one-cycle pulse; B's pixel consumed
- plot_x  out  8  VGA write x
- plot_y  out  7  VGA write y
- plot_colour  out  3  VGA write colour
- plot_en  out  1  VGA write enable
- busy  out  1  high while in CLEAR
- clear_done  out  1  one-cycle pulse at end of a clear
- err_oob  out  1  one-cycle pulse; an out-of-range pixel was dropped

Behaviour:
- Reset (async, active-high):
  - All outputs 0, cx=cy=0, rr pointer = A.
  - State = CLEAR if CLEAR_ON_RESET=1, else ARB.
  - Clear colour register = 0.
  - Reset asserted mid-sweep or mid-handshake aborts immediately; no ack or clear_done is issued afterwards.
- States:
  - ARB: normal arbitration.
  - CLEAR: sweep engine owns the write port.
- CLEAR:
  - Each cycle: plot_x<=cx, plot_y<=cy, plot_colour<=clear colour register, plot_en<=1.
  - cx increments 0..X_MAX, then wraps to 0 and cy increments.
  - The write after (X_MAX,Y_MAX) is the final one. Next state = ARB, cx=cy=0; clear_done pulses in the same cycle plot_en is low again.
  - Total (X_MAX+1)*(Y_MAX+1) = 19200 consecutive plot_en cycles.
  - busy=1 throughout. ack_a=ack_b=0. clear_req is ignored.
- Entering CLEAR from ARB:
  - clear_req=1 in ARB: at that edge, state<=CLEAR and clear colour register<=clear_colour.
  - No grant is issued in that cycle; clear_req has priority over pending requests.
  - The first sweep pixel appears on the following edge.
- ARB, eligibility and arbitration:
  - Requester X is eligible when req_X=1 and ack_X=0. A requester is never granted in the cycle its own ack is high.
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant goes to the one not pointed to by rr; rr then points to the granted one.
  - rr updates only on a grant.
- ARB, grant (at the clock edge):
  - ack_X<=1 for exactly one cycle.
  - plot_x/plot_y/plot_colour<=X's fields.
  - plot_en<=1 unless x_X>X_MAX or y_X>Y_MAX. In that case plot_en<=0 and err_oob<=1; ack is still given.
  - With no grant: plot_en<=0 and acks <=0. plot_x/plot_y/plot_colour hold their last values.
- Requester contract:
  - Hold req and pixel fields stable until the ack cycle.
  - On the edge ending the ack cycle, drop req or present the next pixel.
- Latency and throughput:
  - Latency: request seen at edge N gives ack and plot_en during cycle N+1.
  - Single requester: 1 pixel per 2 cycles.
  - Both requesting: 1 pixel per cycle, alternating A,B,A,B.

Test Plan:
- CLEAR_ON_RESET=1, clear_colour=3'b101 latched before reset: expect 19200 consecutive plot_en cycles with colour 0 (reset value of the clear colour register), first (0,0), last (159,119). clear_done pulses once, busy falls in the same cycle, then ARB.
- ARB, req_a held with (10,20,3'b010), B idle: ack_a and plot_en on alternating cycles, plot_x=10, plot_y=20 each time, ack_b=0.
- req_a and req_b high continuously with distinct pixels: acks strictly alternate A,B,A,B after the first grant. plot_en high every cycle; plot fields match the acked requester.
- req_b with x_b=8'd200, y_b=5: ack_b pulses, plot_en=0, err_oob=1 for one cycle. Then x_b=159, y_b=119: plot_en=1, err_oob=0.
- clear_req pulsed with req_a pending and clear_colour=3'b001: no ack_a while busy=1 and all sweep pixels have colour 001. A second clear_req mid-sweep is ignored, so the sweep still totals 19200 writes. ack_a arrives after clear_done.
- reset asserted at cx=50, cy=30 during a sweep with CLEAR_ON_RESET=0: all outputs 0 asynchronously. After release, state is ARB, no clear_done, and req_a is granted on the next edge.

Source files
------------

// File: rtl/vga_write_arbiter_if.sv
// Signal bundle between the pixel requesters / clear control and the VGA write arbiter.
// The master side drives requests and clears; the slave side is the arbiter that owns the plot port.
interface vga_write_arbiter_if;
  logic       clear_req;
  logic [2:0] clear_colour;

  logic       req_a;
  logic [7:0] x_a;
  logic [6:0] y_a;
  logic [2:0] colour_a;
  logic       ack_a;

  logic       req_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] colour_b;
  logic       ack_b;

  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_en;

  logic       busy;
  logic       clear_done;
  logic       err_oob;

  modport master (
    output clear_req, clear_colour,
    output req_a, x_a, y_a, colour_a,
    output req_b, x_b, y_b, colour_b,
    input  ack_a, ack_b,
    input  plot_x, plot_y, plot_colour, plot_en,
    input  busy, clear_done, err_oob
  );

  modport slave (
    input  clear_req, clear_colour,
    input  req_a, x_a, y_a, colour_a,
    input  req_b, x_b, y_b, colour_b,
    output ack_a, ack_b,
    output plot_x, plot_y, plot_colour, plot_en,
    output busy, clear_done, err_oob
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Sole owner of the VGA write port: round-robin arbitration between two pixel requesters
// plus a full-screen clear sweep engine. Every bus output comes straight from a register.
module vga_write_arbiter #(
  parameter int unsigned X_MAX          = 159,
  parameter int unsigned Y_MAX          = 119,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                clk,
  input logic                reset,
  vga_write_arbiter_if.slave bus
);

  localparam logic [7:0] XMax = X_MAX[7:0];
  localparam logic [6:0] YMax = Y_MAX[6:0];
  localparam logic       RrA  = 1'b0;
  localparam logic       RrB  = 1'b1;

  typedef enum logic {StArb, StClear} state_e;

  state_e     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [2:0] clr_colour_q, clr_colour_d;
  logic       rr_q, rr_d;

  logic [7:0] plot_x_q, plot_x_d;
  logic [6:0] plot_y_q, plot_y_d;
  logic [2:0] plot_colour_q, plot_colour_d;
  logic       plot_en_q, plot_en_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       busy_q, busy_d;
  logic       clear_done_q, clear_done_d;
  logic       err_oob_q, err_oob_d;

  logic       elig_a, elig_b;
  logic       pick_a, pick_b;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  logic       sel_oob;

  // A requester whose ack is currently high is finishing its handshake and must not be regranted.
  always_comb begin
    elig_a     = bus.req_a & ~ack_a_q;
    elig_b     = bus.req_b & ~ack_b_q;
    pick_a     = elig_a & (~elig_b | (rr_q == RrB));
    pick_b     = elig_b & (~elig_a | (rr_q == RrA));
    sel_x      = pick_b ? bus.x_b      : bus.x_a;
    sel_y      = pick_b ? bus.y_b      : bus.y_a;
    sel_colour = pick_b ? bus.colour_b : bus.colour_a;
    sel_oob    = (sel_x > XMax) | (sel_y > YMax);
  end

  always_comb begin
    state_d       = state_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    clr_colour_d  = clr_colour_q;
    rr_d          = rr_q;
    plot_x_d      = plot_x_q;
    plot_y_d      = plot_y_q;
    plot_colour_d = plot_colour_q;
    plot_en_d     = 1'b0;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    busy_d        = 1'b0;
    clear_done_d  = 1'b0;
    err_oob_d     = 1'b0;

    unique case (state_q)
      StClear: begin
        busy_d        = 1'b1;
        plot_x_d      = cx_q;
        plot_y_d      = cy_q;
        plot_colour_d = clr_colour_q;
        plot_en_d     = 1'b1;
        if (cx_q == XMax) begin
          cx_d = '0;
          if (cy_q == YMax) begin
            cy_d    = '0;
            state_d = StArb;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      StArb: begin
        if (busy_q) begin
          // Trailing cycle of a sweep: the final write is on the bus, so close the clear out here.
          clear_done_d = 1'b1;
        end else if (bus.clear_req) begin
          state_d      = StClear;
          clr_colour_d = bus.clear_colour;
          busy_d       = 1'b1;
        end else if (pick_a | pick_b) begin
          ack_a_d       = pick_a;
          ack_b_d       = pick_b;
          rr_d          = pick_b ? RrB : RrA;
          plot_x_d      = sel_x;
          plot_y_d      = sel_y;
          plot_colour_d = sel_colour;
          plot_en_d     = ~sel_oob;
          err_oob_d     = sel_oob;
        end
      end

      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        state_q <= StClear;
      end else begin
        state_q <= StArb;
      end
      cx_q          <= '0;
      cy_q          <= '0;
      clr_colour_q  <= '0;
      rr_q          <= RrA;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
      plot_en_q     <= 1'b0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      busy_q        <= 1'b0;
      clear_done_q  <= 1'b0;
      err_oob_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      clr_colour_q  <= clr_colour_d;
      rr_q          <= rr_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
      plot_en_q     <= plot_en_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      busy_q        <= busy_d;
      clear_done_q  <= clear_done_d;
      err_oob_q     <= err_oob_d;
    end
  end

  assign bus.plot_x      = plot_x_q;
  assign bus.plot_y      = plot_y_q;
  assign bus.plot_colour = plot_colour_q;
  assign bus.plot_en     = plot_en_q;
  assign bus.ack_a       = ack_a_q;
  assign bus.ack_b       = ack_b_q;
  assign bus.busy        = busy_q;
  assign bus.clear_done  = clear_done_q;
  assign bus.err_oob     = err_oob_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench: drivers push expected pixels per requester / per sweep, negedge monitors pop
// and compare whenever the arbiter acks or writes.
module tb_vga_write_arbiter;
  localparam int NPIX = 160 * 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  vga_write_arbiter_if if0 ();
  vga_write_arbiter_if if1 ();

  vga_write_arbiter #(.X_MAX(159), .Y_MAX(119), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (if0)
  );
  vga_write_arbiter #(.X_MAX(159), .Y_MAX(119), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (if1)
  );

  pix_t qa[$], qb[$], cq0[$], cq1[$];
  bit   log_who[$];
  int   log_cyc[$];
  bit   log_en = 1'b0;
  int   checks = 0, failures = 0;
  int   cyc = 0, done0_cnt = 0, done1_cnt = 0, done0_cyc = 0;
  logic prev_busy1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_oob(input pix_t p);
    return (p.x > 8'd159) || (p.y > 7'd119);
  endfunction

  function automatic pix_t rand_pix(input bit allow_oob);
    pix_t p;
    p.x = allow_oob ? 8'($urandom_range(0, 175)) : 8'($urandom_range(0, 159));
    p.y = allow_oob ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 119));
    p.c = 3'($urandom_range(0, 7));
    return p;
  endfunction

  function automatic logic [24:0] outs(input bit which);
    if (which) return {if1.ack_a, if1.ack_b, if1.plot_x, if1.plot_y, if1.plot_colour,
                       if1.plot_en, if1.busy, if1.clear_done, if1.err_oob};
    return {if0.ack_a, if0.ack_b, if0.plot_x, if0.plot_y, if0.plot_colour,
            if0.plot_en, if0.busy, if0.clear_done, if0.err_oob};
  endfunction

  // Full-screen sweep expectation: row-major from (0,0) to (159,119).
  task automatic push_sweep(input bit which, input logic [2:0] c);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        if (which) cq1.push_back(pix_t'({8'(x), 7'(y), c}));
        else cq0.push_back(pix_t'({8'(x), 7'(y), c}));
  endtask

  // Present one pixel on dut0, wait for its ack, return just after the edge ending the ack cycle.
  task automatic send(input bit is_b, input pix_t p);
    int n = 0;
    if (is_b) begin
      qb.push_back(p);
      if0.req_b = 1'b1; if0.x_b = p.x; if0.y_b = p.y; if0.colour_b = p.c;
    end else begin
      qa.push_back(p);
      if0.req_a = 1'b1; if0.x_a = p.x; if0.y_a = p.y; if0.colour_a = p.c;
    end
    do begin
      @(posedge clk); #1; n++;
    end while (!(is_b ? if0.ack_b : if0.ack_a) && n < 25000);
    if (n >= 25000) begin
      checks++; failures++;
      $display("FAIL send_timeout side=%0d: got no ack, required an ack", is_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic score_ack(input bit is_b, input pix_t got, input logic en, input logic oob,
                           input logic other_ack, input logic busy);
    pix_t e;
    check($sformatf("ack%0d_exclusive", is_b), other_ack, 1'b0);
    check($sformatf("ack%0d_not_busy", is_b), busy, 1'b0);
    if ((is_b ? qb.size() : qa.size()) == 0) begin
      check($sformatf("ack%0d_unexpected", is_b), 1'b1, 1'b0);
      return;
    end
    e = is_b ? qb.pop_front() : qa.pop_front();
    check($sformatf("ack%0d_pixel", is_b), got, e);
    check($sformatf("ack%0d_plot_en", is_b), en, !is_oob(e));
    check($sformatf("ack%0d_err_oob", is_b), oob, is_oob(e));
    if (log_en) begin
      log_who.push_back(is_b);
      log_cyc.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst0) begin
      pix_t got;
      got = pix_t'({if0.plot_x, if0.plot_y, if0.plot_colour});
      if (if0.ack_a) score_ack(1'b0, got, if0.plot_en, if0.err_oob, if0.ack_b, if0.busy);
      if (if0.ack_b) score_ack(1'b1, got, if0.plot_en, if0.err_oob, if0.ack_a, if0.busy);
      if (if0.err_oob && !if0.ack_a && !if0.ack_b) check("oob_without_ack", if0.err_oob, 1'b0);
      if (if0.plot_en && !if0.ack_a && !if0.ack_b) begin
        if (cq0.size() == 0) check("clear0_unexpected", if0.plot_en, 1'b0);
        else check("clear0_pixel", got, cq0.pop_front());
      end else if (!if0.plot_en && cq0.size() > 0 && cq0.size() < NPIX) begin
        check("clear0_gap", if0.plot_en, 1'b1);
      end
      if (if0.clear_done) begin
        done0_cnt++;
        done0_cyc = cyc;
        check("done0_sweep_left", cq0.size(), 0);
        check("done0_busy", if0.busy, 1'b0);
        check("done0_plot_en", if0.plot_en, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1) begin
      if (if1.ack_a || if1.ack_b || if1.err_oob)
        check("dut1_spurious", {if1.ack_a, if1.ack_b, if1.err_oob}, 3'b000);
      if (if1.plot_en) begin
        if (cq1.size() == 0) check("clear1_unexpected", if1.plot_en, 1'b0);
        else check("clear1_pixel", {if1.plot_x, if1.plot_y, if1.plot_colour}, cq1.pop_front());
      end else if (cq1.size() > 0 && cq1.size() < NPIX) begin
        check("clear1_gap", if1.plot_en, 1'b1);
      end
      if (if1.clear_done) begin
        done1_cnt++;
        check("done1_sweep_left", cq1.size(), 0);
        check("done1_busy_falls", {prev_busy1, if1.busy}, 2'b10);
      end
      prev_busy1 = if1.busy;
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got no completion, required finish within 95000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, saved;
    pix_t p;
    rst0 = 1'b1;
    rst1 = 1'b1;
    {if0.clear_req, if0.clear_colour, if0.req_a, if0.x_a, if0.y_a, if0.colour_a} = '0;
    {if0.req_b, if0.x_b, if0.y_b, if0.colour_b} = '0;
    {if1.clear_req, if1.clear_colour, if1.req_a, if1.x_a, if1.y_a, if1.colour_a} = '0;
    {if1.req_b, if1.x_b, if1.y_b, if1.colour_b} = '0;
    if1.clear_colour = 3'b101;
    push_sweep(1'b1, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_dut0", outs(1'b0), '0);
    check("reset_outs_dut1", outs(1'b1), '0);
    @(negedge clk);
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Power-on sweep on dut1 uses the reset value of the clear colour register.
    n = 0;
    while (done1_cnt == 0 && n < NPIX + 100) begin
      @(posedge clk); n++;
    end
    check("t1_done_in_time", done1_cnt != 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("t1_done_count", done1_cnt, 1);
    check("t1_busy_after", if1.busy, 1'b0);

    // Lone requester A, same pixel held: one pixel every second cycle.
    log_en = 1'b1;
    log_who.delete(); log_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send(1'b0, pix_t'({8'd10, 7'd20, 3'b010}));
    if0.req_a = 1'b0;
    check("t2_ack_count", log_who.size(), 6);
    for (int i = 0; i < log_who.size(); i++) check("t2_only_a", log_who[i], 1'b0);
    for (int i = 1; i < log_cyc.size(); i++) check("t2_spacing", log_cyc[i] - log_cyc[i-1], 2);

    // Both requesting continuously: one pixel per cycle, strict alternation.
    repeat (3) @(posedge clk);
    #1;
    log_who.delete(); log_cyc.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'b0, rand_pix(1'b0));
        if0.req_a = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) send(1'b1, rand_pix(1'b0));
        if0.req_b = 1'b0;
      end
    join
    check("t3_ack_count", log_who.size(), 16);
    for (int i = 1; i < log_who.size(); i++) begin
      check("t3_alternate", log_who[i] ^ log_who[i-1], 1'b1);
      check("t3_back_to_back", log_cyc[i] - log_cyc[i-1], 1);
    end
    log_en = 1'b0;

    // Out-of-range drops and the exact in-range corner.
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, pix_t'({8'd200, 7'd5, 3'b011}));
    send(1'b1, pix_t'({8'd10, 7'd120, 3'b011}));
    send(1'b1, pix_t'({8'd159, 7'd119, 3'b110}));
    send(1'b1, pix_t'({8'd160, 7'd0, 3'b001}));
    if0.req_b = 1'b0;

    // Randomised traffic with idle gaps, some pixels out of range.
    repeat (2) @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 40; i++) begin
        int gap;
        send(1'b0, rand_pix(1'b1));
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          if0.req_a = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < 40; i++) begin
        int gap;
        send(1'b1, rand_pix(1'b1));
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          if0.req_b = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
      end
    join
    if0.req_a = 1'b0;
    if0.req_b = 1'b0;
    check("rand_a_drained", qa.size(), 0);
    check("rand_b_drained", qb.size(), 0);

    // Clear beats a pending request; a second clear_req mid-sweep is ignored.
    repeat (2) @(posedge clk);
    #1;
    saved = done0_cnt;
    log_en = 1'b1;
    log_who.delete(); log_cyc.delete();
    fork
      begin
        send(1'b0, pix_t'({8'd33, 7'd44, 3'b111}));
        if0.req_a = 1'b0;
      end
      begin
        push_sweep(1'b0, 3'b001);
        if0.clear_req = 1'b1;
        if0.clear_colour = 3'b001;
        @(posedge clk); #1;
        if0.clear_req = 1'b0;
        if0.clear_colour = 3'b110;
        repeat (1000) @(posedge clk);
        #1;
        check("t5_busy_mid_sweep", if0.busy, 1'b1);
        if0.clear_req = 1'b1;
        @(posedge clk); #1;
        if0.clear_req = 1'b0;
      end
    join
    log_en = 1'b0;
    check("t5_done_count", done0_cnt - saved, 1);
    check("t5_ack_count", log_cyc.size(), 1);
    if (log_cyc.size() > 0) check("t5_ack_after_done", log_cyc[0] > done0_cyc, 1'b1);

    // Reset mid-sweep aborts everything; dut0 comes back in arbitration.
    repeat (2) @(posedge clk);
    #1;
    saved = done0_cnt;
    push_sweep(1'b0, 3'b100);
    if0.clear_req = 1'b1;
    if0.clear_colour = 3'b100;
    @(posedge clk); #1;
    if0.clear_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(if0.plot_en && if0.plot_x == 8'd50 && if0.plot_y == 7'd30) && n < 6000);
    check("t6_reached_50_30", n < 6000, 1'b1);
    #2;
    rst0 = 1'b1;
    #1;
    check("t6_async_reset_outs", outs(1'b0), '0);
    cq0.delete();
    p = pix_t'({8'd77, 7'd66, 3'b101});
    qa.push_back(p);
    if0.req_a = 1'b1; if0.x_a = p.x; if0.y_a = p.y; if0.colour_a = p.c;
    repeat (3) @(negedge clk);
    #2;
    rst0 = 1'b0;
    @(posedge clk); #1;
    check("t6_grant_next_edge", {if0.ack_a, if0.plot_en, if0.busy}, 3'b110);
    @(posedge clk); #1;
    if0.req_a = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_clear_done", done0_cnt - saved, 0);
    check("t6_idle_plot_en", if0.plot_en, 1'b0);

    check("end_qa_empty", qa.size(), 0);
    check("end_qb_empty", qb.size(), 0);
    check("end_cq1_empty", cq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
